change_dispenser_ctrl: RTL and testbench
========================================

Name: change_dispenser_ctrl

Overview:
- Sequences the coin-return hopper of the newspaper vending machine.
- Accepts a change amount from the vend FSM, measured in nickel units, and issues one eject pulse at a time for dimes and nickels.
- Waits for the hopper's drop acknowledge after each pulse and tracks per-coin inventory.
- Prefers dimes and falls back to nickels. If the request cannot be completed from stock, or the hopper jams, it reports a shortfall.

Parameters:
- AMT_W, 4: width of change amount in nickel units (max 15 = 75c).
- CNT_W, 6: width of each coin inventory counter; saturates at 2^CNT_W-1.
- D_INIT, 8: dime count loaded at reset.
- N_INIT, 8: nickel count loaded at reset.
- ACK_TO, 15: cycles to wait for hopper_ack before declaring a jam.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  change request present.
- req_amt  in  AMT_W  change due, in nickels.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- eject_d  out  1  one-cycle pulse: drop one dime.
- eject_n  out  1  one-cycle pulse: drop one nickel.
- hopper_ack  in  1  single-cycle pulse: the last ejected coin has dropped.
- refill_d  in  1  pulse: add one dime to inventory.
- refill_n  in  1  pulse: add one nickel to inventory.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: full amount returned.
- short_err  out  1  one-cycle pulse: dispense ended with money still owed.
- short_amt  out  AMT_W  nickels still owed; valid while short_err is high, 0 otherwise.
- d_count  out  CNT_W  current dime inventory.
- n_count  out  CNT_W  current nickel inventory.

Behaviour:

Reset values:
- Async reset forces state=IDLE.
- All pulses are 0 and short_amt=0.
- remaining=0, timer=0.
- d_count=D_INIT, n_count=N_INIT.
- Reset mid-dispense abandons the request; no done or short_err is issued.

FSM states: IDLE, SELECT, EJ_D, EJ_N, WAIT_D, WAIT_N, DONE, SHORT.
- IDLE:
  - On accept, latch remaining=req_amt and go to SELECT next cycle.
  - req_amt=0 still passes through SELECT, which goes straight to DONE.
- SELECT: checked in this priority order.
  1. remaining=0 -> DONE.
  2. remaining>=2 and d_count>0 -> EJ_D.
  3. remaining>=1 and n_count>0 -> EJ_N.
  4. Otherwise -> SHORT.
- EJ_D / EJ_N:
  - Assert eject_d / eject_n for exactly one cycle.
  - Clear timer and go to WAIT_D / WAIT_N.
- WAIT_D:
  - On hopper_ack: remaining -= 2, d_count -= 1, go to SELECT.
  - Otherwise timer increments.
  - When timer reaches ACK_TO-1 with no ack, go to SHORT. The coin is treated as not dispensed, so inventory and remaining are unchanged.
- WAIT_N: same as WAIT_D, but remaining -= 1 and n_count -= 1.
- DONE: done=1 for one cycle, then IDLE.
- SHORT: short_err=1 and short_amt=remaining for one cycle, then IDLE.
- hopper_ack outside WAIT_D/WAIT_N is ignored.

Latency: from accept, a coin's eject pulse appears 2 cycles later. After each ack, the next eject pulse appears 2 cycles later.

Inventory rules:
- Refill in the same cycle as a decrement of the same coin gives a net change of 0.
- Refill when the counter is at max saturates; the coin is lost and no error is raised.
- Refill is accepted in every state.

Arithmetic:
- remaining never underflows, because the SELECT guards prevent it.
- All counters are unsigned.

Decomposition:
- Package vend_pkg:
  - disp_state_e enum.
  - Coin value constants in nickel units: NICKEL_U=1, DIME_U=2, QUARTER_U=5.
  - Price constant PRICE_U=7 (35c), shared with the vend FSM.
- One natural sub-module, coin_inventory, instanced twice (dime, nickel):
  - Inputs: clk, rst_n, INIT parameter, inc, dec.
  - Output: count.
  - Behaviour: saturating up-count, inc+dec = hold.

Test Plan:
1. D_INIT=8, N_INIT=8, req_amt=3 (15c), ack 3 cycles after each pulse -> eject_d, then eject_n, then done. Result: d_count=7, n_count=7, short_err never asserted.
2. D_INIT=0, req_amt=4 (20c) -> four eject_n pulses, no eject_d, done, n_count=4.
3. N_INIT=0, D_INIT=8, req_amt=1 -> no eject, short_err with short_amt=1, two cycles after accept.
4. req_amt=0 -> done two cycles after accept, no ejects, inventory unchanged.
5. req_amt=2, hopper_ack never asserted -> eject_d, then short_err with short_amt=2 after ACK_TO cycles in WAIT_D. d_count is unchanged.
6. Two cases:
   - refill_d and hopper_ack in the same WAIT_D cycle -> d_count unchanged.
   - rst_n low during WAIT_N -> IDLE immediately, counts return to INIT, no done or short_err.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending machine datapath.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJ_D,
        S_EJ_N,
        S_WAIT_D,
        S_WAIT_N,
        S_DONE,
        S_SHORT
    } disp_state_e;

    // Coin values in nickel units
    localparam int unsigned NICKEL_U  = 1;
    localparam int unsigned DIME_U    = 2;
    localparam int unsigned QUARTER_U = 5;

    // Newspaper price in nickel units (35c)
    localparam int unsigned PRICE_U   = 7;

endpackage

// File: rtl/change_dispenser_ctrl_coin_inventory.sv
// Saturating per-coin inventory counter; simultaneous inc and dec hold the value.
module coin_inventory #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned INIT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: saturate at max on refill, never wrap below zero
    always_comb begin
        count_d = count_q;
        case ({inc, dec})
            2'b10:   if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
            2'b01:   if (count_q != '0)      count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Count register, reloaded with the initial stock on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= CNT_W'(INIT);
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Coin-return hopper sequencer: pays change in dimes first, then nickels,
// one eject at a time with an ack timeout, and reports any shortfall.
module change_dispenser_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W  = 4,
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned D_INIT = 8,
    parameter int unsigned N_INIT = 8,
    parameter int unsigned ACK_TO = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    output logic             eject_d,
    output logic             eject_n,
    input  logic             hopper_ack,
    input  logic             refill_d,
    input  logic             refill_n,
    output logic             busy,
    output logic             done,
    output logic             short_err,
    output logic [AMT_W-1:0] short_amt,
    output logic [CNT_W-1:0] d_count,
    output logic [CNT_W-1:0] n_count
);

    localparam int unsigned TMR_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dec_d_c, dec_n_c;

    logic             req_ready_q, busy_q, eject_d_q, eject_n_q, done_q, short_err_q;
    logic [AMT_W-1:0] short_amt_q;

    // Next-state, remaining-change and ack-timer logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        dec_d_c     = 1'b0;
        dec_n_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    remaining_d = req_amt;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == '0)
                    state_d = S_DONE;
                else if (remaining_q >= AMT_W'(DIME_U) && d_count != '0)
                    state_d = S_EJ_D;
                else if (remaining_q >= AMT_W'(NICKEL_U) && n_count != '0)
                    state_d = S_EJ_N;
                else
                    state_d = S_SHORT;
            end
            S_EJ_D: begin
                timer_d = '0;
                state_d = S_WAIT_D;
            end
            S_EJ_N: begin
                timer_d = '0;
                state_d = S_WAIT_N;
            end
            S_WAIT_D: begin
                if (hopper_ack) begin
                    remaining_d = remaining_q - AMT_W'(DIME_U);
                    dec_d_c     = 1'b1;
                    state_d     = S_SELECT;
                end else if (timer_q == TMR_W'(ACK_TO - 1)) begin
                    state_d = S_SHORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_N: begin
                if (hopper_ack) begin
                    remaining_d = remaining_q - AMT_W'(NICKEL_U);
                    dec_n_c     = 1'b1;
                    state_d     = S_SELECT;
                end else if (timer_q == TMR_W'(ACK_TO - 1)) begin
                    state_d = S_SHORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_SHORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            eject_d_q   <= 1'b0;
            eject_n_q   <= 1'b0;
            done_q      <= 1'b0;
            short_err_q <= 1'b0;
            short_amt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            req_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            eject_d_q   <= (state_d == S_EJ_D);
            eject_n_q   <= (state_d == S_EJ_N);
            done_q      <= (state_d == S_DONE);
            short_err_q <= (state_d == S_SHORT);
            short_amt_q <= (state_d == S_SHORT) ? remaining_d : '0;
        end
    end

    coin_inventory #(.CNT_W(CNT_W), .INIT(D_INIT)) u_dime_inv (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (refill_d),
        .dec   (dec_d_c),
        .count (d_count)
    );

    coin_inventory #(.CNT_W(CNT_W), .INIT(N_INIT)) u_nickel_inv (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (refill_n),
        .dec   (dec_n_c),
        .count (n_count)
    );

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign eject_d   = eject_d_q;
    assign eject_n   = eject_n_q;
    assign done      = done_q;
    assign short_err = short_err_q;
    assign short_amt = short_amt_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Directed bench for the change dispenser sequencer.
module tb_change_dispenser_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_amt;
    logic       req_ready;
    logic       eject_d, eject_n;
    logic       hopper_ack, refill_d, refill_n;
    logic       busy, done, short_err;
    logic [3:0] short_amt;
    logic [5:0] d_count, n_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    change_dispenser_ctrl #(
        .AMT_W(4), .CNT_W(6), .D_INIT(8), .N_INIT(8), .ACK_TO(15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_amt    (req_amt),
        .req_ready  (req_ready),
        .eject_d    (eject_d),
        .eject_n    (eject_n),
        .hopper_ack (hopper_ack),
        .refill_d   (refill_d),
        .refill_n   (refill_n),
        .busy       (busy),
        .done       (done),
        .short_err  (short_err),
        .short_amt  (short_amt),
        .d_count    (d_count),
        .n_count    (n_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request and play the hopper: ack ack_dly cycles after each
    // eject (0 = never). Cycle 0 is the accept cycle. Returns at the negedge
    // of the cycle where done or short_err was seen, or after a cycle budget.
    task automatic run_req(input int amt, input int ack_dly, input bit refill_on_ack,
                           output int nd, output int nn, output int dn,
                           output int sh, output int samt, output int lat);
        int ack_at;
        nd = 0; nn = 0; dn = 0; sh = 0; samt = 0; lat = -1; ack_at = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_amt   = 4'(amt);
        @(negedge clk);
        req_valid = 1'b0;
        req_amt   = 4'd0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            hopper_ack = 1'b0;
            refill_d   = 1'b0;
            if (cyc == ack_at) begin
                hopper_ack = 1'b1;
                refill_d   = refill_on_ack;
                ack_at     = -1;
            end
            if (eject_d) begin
                nd++;
                if (ack_dly > 0) ack_at = cyc + ack_dly;
            end
            if (eject_n) begin
                nn++;
                if (ack_dly > 0) ack_at = cyc + ack_dly;
            end
            if (done) begin
                dn = 1; lat = cyc;
                break;
            end
            if (short_err) begin
                sh = 1; samt = int'(short_amt); lat = cyc;
                break;
            end
            @(negedge clk);
        end
        hopper_ack = 1'b0;
        refill_d   = 1'b0;
    endtask

    initial begin
        int nd, nn, dn, sh, samt, lat;
        int seen;

        rst_n = 1'b0; req_valid = 1'b0; req_amt = 4'd0;
        hopper_ack = 1'b0; refill_d = 1'b0; refill_n = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({eject_d, eject_n, done, short_err}), 0);
        check("rst_short_amt", int'(short_amt), 0);
        check("rst_d_count", int'(d_count), 8);
        check("rst_n_count", int'(n_count), 8);
        rst_n = 1'b1;
        @(negedge clk);

        // 15c: one dime, one nickel, ack 3 cycles after each eject
        run_req(3, 3, 1'b0, nd, nn, dn, sh, samt, lat);
        check("t1_dimes", nd, 1);
        check("t1_nickels", nn, 1);
        check("t1_done", dn, 1);
        check("t1_short", sh, 0);
        check("t1_latency", lat, 12);
        @(negedge clk);
        check("t1_done_pulse_width", int'(done), 0);
        check("t1_back_idle", int'(req_ready), 1);
        check("t1_d_count", int'(d_count), 7);
        check("t1_n_count", int'(n_count), 7);

        // Zero amount: straight to done
        run_req(0, 1, 1'b0, nd, nn, dn, sh, samt, lat);
        check("t4_ejects", nd + nn, 0);
        check("t4_done", dn, 1);
        check("t4_latency", lat, 2);
        @(negedge clk);
        check("t4_d_count", int'(d_count), 7);
        check("t4_n_count", int'(n_count), 7);

        // Refill in the same cycle as a dime ack: net no change
        run_req(2, 2, 1'b1, nd, nn, dn, sh, samt, lat);
        check("t6a_dimes", nd, 1);
        check("t6a_done", dn, 1);
        @(negedge clk);
        check("t6a_d_count", int'(d_count), 7);

        // No ack: jam after ACK_TO cycles in WAIT_D
        run_req(2, 0, 1'b0, nd, nn, dn, sh, samt, lat);
        check("t5_dimes", nd, 1);
        check("t5_short", sh, 1);
        check("t5_short_amt", samt, 2);
        check("t5_latency", lat, 18);
        @(negedge clk);
        check("t5_short_pulse_width", int'(short_err), 0);
        check("t5_short_amt_clear", int'(short_amt), 0);
        check("t5_d_count", int'(d_count), 7);

        // Drain all dimes with 70c
        run_req(14, 1, 1'b0, nd, nn, dn, sh, samt, lat);
        check("drain_dimes", nd, 7);
        check("drain_done", dn, 1);
        @(negedge clk);
        check("drain_d_count", int'(d_count), 0);

        // No dimes: 20c as four nickels
        run_req(4, 1, 1'b0, nd, nn, dn, sh, samt, lat);
        check("t2_dimes", nd, 0);
        check("t2_nickels", nn, 4);
        check("t2_done", dn, 1);
        @(negedge clk);
        check("t2_n_count", int'(n_count), 3);

        // 25c with only three nickels: partial pay, 2 still owed
        run_req(5, 1, 1'b0, nd, nn, dn, sh, samt, lat);
        check("part_nickels", nn, 3);
        check("part_short", sh, 1);
        check("part_short_amt", samt, 2);
        @(negedge clk);
        check("part_n_count", int'(n_count), 0);

        // Empty stock: 5c short immediately
        run_req(1, 1, 1'b0, nd, nn, dn, sh, samt, lat);
        check("t3_ejects", nd + nn, 0);
        check("t3_short", sh, 1);
        check("t3_short_amt", samt, 1);
        check("t3_latency", lat, 2);

        // Refills in IDLE: two nickels, one dime
        @(negedge clk);
        refill_n = 1'b1; refill_d = 1'b1;
        @(negedge clk);
        refill_d = 1'b0;
        @(negedge clk);
        refill_n = 1'b0;
        check("refill_d_count", int'(d_count), 1);
        check("refill_n_count", int'(n_count), 2);

        // Saturation at 63
        refill_d = 1'b1;
        repeat (70) @(negedge clk);
        refill_d = 1'b0;
        check("sat_d_count", int'(d_count), 63);

        // Stray ack in IDLE is ignored
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_d", int'(d_count), 63);
        check("idle_ack_n", int'(n_count), 2);
        check("idle_ack_busy", int'(busy), 0);

        // Reset during WAIT_N abandons the request
        req_valid = 1'b1; req_amt = 4'd1;
        @(negedge clk);
        req_valid = 1'b0; req_amt = 4'd0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (eject_n) seen = 1;
            else @(negedge clk);
        end
        check("t6b_eject_n_seen", seen, 1);
        @(negedge clk);
        check("t6b_busy_in_wait", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6b_busy_after_rst", int'(busy), 0);
        check("t6b_ready_after_rst", int'(req_ready), 1);
        check("t6b_d_count", int'(d_count), 8);
        check("t6b_n_count", int'(n_count), 8);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || short_err || eject_d || eject_n) seen = 1;
        end
        check("t6b_no_pulses", seen, 0);
        check("t6b_idle", int'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
